// File: rtl/l2_way_writer_if.sv
// l2_way_writer_if
// Bundles the request handshake and the L2 data-array side of the
// l2_way_writer block.
//   slave  modport : the writer itself (takes requests, drives the arrays)
//   master modport : whoever offers requests and returns array read data
// Signals:
//   req_valid/req_ready            request handshake
//   req_way/req_index/req_data/req_mask  request payload (one-hot way, byte mask)
//   rd_en/rd_way                   merge read strobe and read-mux select
//   arr_rdata                      muxed array data, valid the cycle after rd_en
//   arr_index                      array address shared by read and write
//   way_we/arr_wdata               one-hot way write enable and merged line
//   done/way_err                   completion pulse / bad-way pulse
interface l2_way_writer_if #(
    parameter int INDEX_WIDTH = 3,
    parameter int LINE_BYTES  = 16
);
    logic                   req_valid;
    logic                   req_ready;
    logic [3:0]             req_way;
    logic [INDEX_WIDTH-1:0] req_index;
    logic [127:0]           req_data;
    logic [LINE_BYTES-1:0]  req_mask;
    logic                   rd_en;
    logic [3:0]             rd_way;
    logic [127:0]           arr_rdata;
    logic [INDEX_WIDTH-1:0] arr_index;
    logic [3:0]             way_we;
    logic [127:0]           arr_wdata;
    logic                   done;
    logic                   way_err;

    modport slave (
        input  req_valid, req_way, req_index, req_data, req_mask, arr_rdata,
        output req_ready, rd_en, rd_way, arr_index, way_we, arr_wdata, done, way_err
    );

    modport master (
        output req_valid, req_way, req_index, req_data, req_mask, arr_rdata,
        input  req_ready, rd_en, rd_way, arr_index, way_we, arr_wdata, done, way_err
    );
endinterface

// File: rtl/l2_way_writer.sv
// l2_way_writer
// Write side of the 4-way L2 data arrays. Requests (memory fills and
// byte-masked L1 writebacks) are queued in a small FIFO, then each one is
// applied with a read-modify-write: read the target way, merge the masked
// bytes, write the merged line back with a one-hot way enable.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset (drops queued and in-flight requests)
//   bus  l2_way_writer_if.slave (request handshake + array interface)
// Optional feature macro: L2_WRITER_FULLLINE_FAST_EN
//   When defined, a request with an all-ones mask goes IDLE->WR directly
//   and writes req_data without reading the array.
module l2_way_writer #(
    parameter int INDEX_WIDTH = 3,
    parameter int FIFO_DEPTH  = 2,
    parameter int LINE_BYTES  = 16
) (
    input  logic           clk,
    input  logic           rst,
    l2_way_writer_if.slave bus
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_ZERO = (AW+1)'(0);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_MRG  = 2'd2,
        ST_WR   = 2'd3
    } state_t;

    // True when exactly one bit of the way select is set.
    function automatic logic is_onehot4(input logic [3:0] w);
        return (w != 4'b0000) && ((w & (w - 4'd1)) == 4'b0000);
    endfunction

    // Byte-wise merge: masked bytes come from new data, the rest from the array.
    function automatic logic [127:0] merge_line(input logic [LINE_BYTES-1:0] m,
                                                input logic [127:0] nd,
                                                input logic [127:0] od);
        logic [127:0] r;
        r = od;
        for (int i = 0; i < LINE_BYTES; i++) begin
            if (m[i]) r[i*8 +: 8] = nd[i*8 +: 8];
        end
        return r;
    endfunction

    logic [3:0]             fifo_way_r   [FIFO_DEPTH];
    logic [INDEX_WIDTH-1:0] fifo_index_r [FIFO_DEPTH];
    logic [127:0]           fifo_data_r  [FIFO_DEPTH];
    logic [LINE_BYTES-1:0]  fifo_mask_r  [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_r, rd_ptr_r;
    logic [AW:0]            count_r;

    state_t                 state_r, state_s;
    logic [3:0]             work_way_r;
    logic [INDEX_WIDTH-1:0] work_index_r;
    logic [127:0]           work_data_r;
    logic [LINE_BYTES-1:0]  work_mask_r;

    logic                   full_s, empty_s, push_s, pop_s, latch_s, fast_s;
    logic [3:0]             head_way_s;
    logic [LINE_BYTES-1:0]  head_mask_s;
    logic                   rd_en_s, done_s, way_err_s;
    logic [3:0]             rd_way_s, way_we_s;
    logic [127:0]           wdata_s;

    assign full_s      = (count_r == CNT_FULL);
    assign empty_s     = (count_r == CNT_ZERO);
    assign push_s      = bus.req_valid && !full_s;
    assign pop_s       = (state_r == ST_WR);
    assign latch_s     = (state_r == ST_IDLE) && !empty_s;
    assign head_way_s  = fifo_way_r[rd_ptr_r];
    assign head_mask_s = fifo_mask_r[rd_ptr_r];

`ifdef L2_WRITER_FULLLINE_FAST_EN
    assign fast_s = (head_mask_s == {LINE_BYTES{1'b1}});
`else
    assign fast_s = 1'b0;
`endif

    // FIFO payload storage; only written on an accepted request.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_way_r[wr_ptr_r]   <= bus.req_way;
            fifo_index_r[wr_ptr_r] <= bus.req_index;
            fifo_data_r[wr_ptr_r]  <= bus.req_data;
            fifo_mask_r[wr_ptr_r]  <= bus.req_mask;
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop keeps the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= CNT_ZERO;
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Working copy of the head request; the MRG cycle folds the array data in.
    always_ff @(posedge clk) begin
        if (rst) begin
            work_way_r   <= 4'b0000;
            work_index_r <= {INDEX_WIDTH{1'b0}};
            work_data_r  <= 128'd0;
            work_mask_r  <= {LINE_BYTES{1'b0}};
        end else if (latch_s) begin
            // A malformed way select falls back to way0 so enables stay one-hot.
            work_way_r   <= is_onehot4(head_way_s) ? head_way_s : 4'b0001;
            work_index_r <= fifo_index_r[rd_ptr_r];
            work_data_r  <= fifo_data_r[rd_ptr_r];
            work_mask_r  <= head_mask_s;
        end else if (state_r == ST_MRG) begin
            work_data_r  <= merge_line(work_mask_r, work_data_r, bus.arr_rdata);
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_r <= ST_IDLE;
        else     state_r <= state_s;
    end

    // FSM next-state logic.
    always_comb begin
        state_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) begin
                    if (fast_s) state_s = ST_WR;
                    else        state_s = ST_RD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RD:   state_s = ST_MRG;
            ST_MRG:  state_s = ST_WR;
            ST_WR:   state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // FSM output decode; strobes are suppressed while reset is asserted.
    always_comb begin
        rd_en_s   = 1'b0;
        rd_way_s  = 4'b0000;
        way_we_s  = 4'b0000;
        wdata_s   = 128'd0;
        done_s    = 1'b0;
        way_err_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!rst && !empty_s && !is_onehot4(head_way_s)) way_err_s = 1'b1;
                else                                             way_err_s = 1'b0;
            end
            ST_RD: begin
                if (!rst) begin
                    rd_en_s  = 1'b1;
                    rd_way_s = work_way_r;
                end else begin
                    rd_en_s  = 1'b0;
                end
            end
            ST_MRG: begin
                rd_way_s = work_way_r;
            end
            ST_WR: begin
                if (!rst) begin
                    way_we_s = work_way_r;
                    wdata_s  = work_data_r;
                    done_s   = 1'b1;
                end else begin
                    done_s   = 1'b0;
                end
            end
            default: begin
                rd_en_s = 1'b0;
            end
        endcase
    end

    assign bus.req_ready = !full_s;
    assign bus.rd_en     = rd_en_s;
    assign bus.rd_way    = rd_way_s;
    assign bus.arr_index = work_index_r;
    assign bus.way_we    = way_we_s;
    assign bus.arr_wdata = wdata_s;
    assign bus.done      = done_s;
    assign bus.way_err   = way_err_s;
endmodule

// File: tb/tb_l2_way_writer.sv
// tb_l2_way_writer
// Directed bench for l2_way_writer (INDEX_WIDTH=3, FIFO_DEPTH=2, LINE_BYTES=16).
// The array always returns 8'hAA in every byte. Honours
// L2_WRITER_FULLLINE_FAST_EN for the full-line scenario.
module tb_l2_way_writer;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    l2_way_writer_if #(.INDEX_WIDTH(3), .LINE_BYTES(16)) bus ();

    l2_way_writer #(.INDEX_WIDTH(3), .FIFO_DEPTH(2), .LINE_BYTES(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_req(input logic [3:0] way, input logic [2:0] idx,
                             input logic [15:0] mask, input logic [127:0] data);
        bus.req_valid = 1'b1;
        bus.req_way   = way;
        bus.req_index = idx;
        bus.req_mask  = mask;
        bus.req_data  = data;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++; if (bus.way_we !== 4'b0000) begin bad++; $display("FAIL reset_way_we: got %h want 0", bus.way_we); end
            total++; if (bus.rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en: got %b want 0", bus.rd_en); end
            total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
            total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", bus.req_ready); end
            total++; if (bus.arr_index !== 3'd0) begin bad++; $display("FAIL reset_index: got %h want 0", bus.arr_index); end
            total++; if (bus.arr_wdata !== 128'd0) begin bad++; $display("FAIL reset_wdata: got %h want 0", bus.arr_wdata); end
        end
    endtask

    task automatic test_partial_write();
        logic [127:0] exp_w;
        exp_w = {{12{8'hAA}}, 32'hDEADBEEF};
        drive_req(4'b0100, 3'd3, 16'h000F, {{12{8'h11}}, 32'hDEADBEEF});
        @(negedge clk);  // IDLE sees the request
        bus.req_valid = 1'b0;
        total++; if (bus.rd_en !== 1'b0) begin bad++; $display("FAIL pw_c1_rd_en: got %b want 0", bus.rd_en); end
        @(negedge clk);  // RD
        total++; if (bus.rd_en !== 1'b1) begin bad++; $display("FAIL pw_rd_en: got %b want 1", bus.rd_en); end
        total++; if (bus.rd_way !== 4'b0100) begin bad++; $display("FAIL pw_rd_way: got %h want 4", bus.rd_way); end
        total++; if (bus.arr_index !== 3'd3) begin bad++; $display("FAIL pw_rd_index: got %h want 3", bus.arr_index); end
        @(negedge clk);  // MRG
        total++; if (bus.rd_en !== 1'b0) begin bad++; $display("FAIL pw_mrg_rd_en: got %b want 0", bus.rd_en); end
        total++; if (bus.rd_way !== 4'b0100) begin bad++; $display("FAIL pw_mrg_rd_way: got %h want 4", bus.rd_way); end
        total++; if (bus.way_we !== 4'b0000) begin bad++; $display("FAIL pw_mrg_we: got %h want 0", bus.way_we); end
        @(negedge clk);  // WR
        total++; if (bus.way_we !== 4'b0100) begin bad++; $display("FAIL pw_we: got %h want 4", bus.way_we); end
        total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL pw_done: got %b want 1", bus.done); end
        total++; if (bus.arr_wdata !== exp_w) begin bad++; $display("FAIL pw_wdata: got %h want %h", bus.arr_wdata, exp_w); end
        total++; if (bus.arr_index !== 3'd3) begin bad++; $display("FAIL pw_wr_index: got %h want 3", bus.arr_index); end
        @(negedge clk);  // back to IDLE
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL pw_done_clear: got %b want 0", bus.done); end
        total++; if (bus.way_we !== 4'b0000) begin bad++; $display("FAIL pw_we_clear: got %h want 0", bus.way_we); end
        total++; if (bus.arr_index !== 3'd3) begin bad++; $display("FAIL pw_index_hold: got %h want 3", bus.arr_index); end
    endtask

    task automatic test_full_line();
        logic [127:0] d;
        d = 128'h0123456789ABCDEF_FEDCBA9876543210;
        drive_req(4'b0001, 3'd7, 16'hFFFF, d);
        @(negedge clk);  // cycle 1: IDLE
        bus.req_valid = 1'b0;
        @(negedge clk);  // cycle 2
`ifdef L2_WRITER_FULLLINE_FAST_EN
        total++; if (bus.way_we !== 4'b0001) begin bad++; $display("FAIL fl_fast_we: got %h want 1", bus.way_we); end
        total++; if (bus.rd_en !== 1'b0) begin bad++; $display("FAIL fl_fast_rd_en: got %b want 0", bus.rd_en); end
        total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL fl_fast_done: got %b want 1", bus.done); end
        total++; if (bus.arr_wdata !== d) begin bad++; $display("FAIL fl_fast_wdata: got %h want %h", bus.arr_wdata, d); end
        total++; if (bus.arr_index !== 3'd7) begin bad++; $display("FAIL fl_fast_index: got %h want 7", bus.arr_index); end
`else
        total++; if (bus.rd_en !== 1'b1) begin bad++; $display("FAIL fl_rd_en: got %b want 1", bus.rd_en); end
        total++; if (bus.rd_way !== 4'b0001) begin bad++; $display("FAIL fl_rd_way: got %h want 1", bus.rd_way); end
        total++; if (bus.arr_index !== 3'd7) begin bad++; $display("FAIL fl_rd_index: got %h want 7", bus.arr_index); end
        total++; if (bus.way_we !== 4'b0000) begin bad++; $display("FAIL fl_c2_we: got %h want 0", bus.way_we); end
        @(negedge clk);  // cycle 3: MRG
        @(negedge clk);  // cycle 4: WR
        total++; if (bus.way_we !== 4'b0001) begin bad++; $display("FAIL fl_we: got %h want 1", bus.way_we); end
        total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL fl_done: got %b want 1", bus.done); end
        total++; if (bus.arr_wdata !== d) begin bad++; $display("FAIL fl_wdata: got %h want %h", bus.arr_wdata, d); end
`endif
        @(negedge clk);  // IDLE again
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL fl_done_clear: got %b want 0", bus.done); end
    endtask

    task automatic test_back_to_back();
        logic [127:0] exp_data [3];
        logic [3:0]   exp_way  [3];
        logic [2:0]   exp_idx  [3];
        logic         exp_rdy  [6];
        int           nd;
        exp_data[0] = {{15{8'hAA}}, 8'h11};
        exp_data[1] = {8'h22, {15{8'hAA}}};
        exp_data[2] = {{8{8'hAA}}, {8{8'h33}}};
        exp_way[0] = 4'b0001; exp_way[1] = 4'b0010; exp_way[2] = 4'b1000;
        exp_idx[0] = 3'd1;    exp_idx[1] = 3'd2;    exp_idx[2] = 3'd5;
        exp_rdy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        nd = 0;
        for (int k = 0; k < 16; k++) begin
            if (k < 6) begin
                total++; if (bus.req_ready !== exp_rdy[k]) begin bad++; $display("FAIL b2b_ready_k%0d: got %b want %b", k, bus.req_ready, exp_rdy[k]); end
            end
            if (bus.done === 1'b1) begin
                if (nd < 3) begin
                    total++; if (bus.way_we !== exp_way[nd]) begin bad++; $display("FAIL b2b_we_%0d: got %h want %h", nd, bus.way_we, exp_way[nd]); end
                    total++; if (bus.arr_index !== exp_idx[nd]) begin bad++; $display("FAIL b2b_index_%0d: got %h want %h", nd, bus.arr_index, exp_idx[nd]); end
                    total++; if (bus.arr_wdata !== exp_data[nd]) begin bad++; $display("FAIL b2b_wdata_%0d: got %h want %h", nd, bus.arr_wdata, exp_data[nd]); end
                end
                nd++;
            end
            if (k == 0)      drive_req(4'b0001, 3'd1, 16'h0001, {16{8'h11}});
            else if (k == 1) drive_req(4'b0010, 3'd2, 16'h8000, {16{8'h22}});
            else if (k == 2) drive_req(4'b1000, 3'd5, 16'h00FF, {16{8'h33}});
            else if (k == 6) bus.req_valid = 1'b0;
            @(negedge clk);
        end
        total++; if (nd !== 3) begin bad++; $display("FAIL b2b_done_count: got %0d want 3", nd); end
    endtask

    task automatic test_bad_way();
        drive_req(4'b0110, 3'd2, 16'h0000, {16{8'h55}});
        @(negedge clk);  // IDLE with malformed head
        bus.req_valid = 1'b0;
        total++; if (bus.way_err !== 1'b1) begin bad++; $display("FAIL bw_err: got %b want 1", bus.way_err); end
        @(negedge clk);  // RD
        total++; if (bus.way_err !== 1'b0) begin bad++; $display("FAIL bw_err_clear: got %b want 0", bus.way_err); end
        total++; if (bus.rd_way !== 4'b0001) begin bad++; $display("FAIL bw_rd_way: got %h want 1", bus.rd_way); end
        @(negedge clk);  // MRG
        @(negedge clk);  // WR
        total++; if (bus.way_we !== 4'b0001) begin bad++; $display("FAIL bw_we: got %h want 1", bus.way_we); end
        total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL bw_done: got %b want 1", bus.done); end
        total++; if (bus.arr_wdata !== {16{8'hAA}}) begin bad++; $display("FAIL bw_zero_mask_wdata: got %h want all AA", bus.arr_wdata); end
        total++; if (bus.way_err !== 1'b0) begin bad++; $display("FAIL bw_err_wr: got %b want 0", bus.way_err); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        drive_req(4'b0010, 3'd4, 16'h0F0F, {16{8'h77}});
        @(negedge clk);  // IDLE
        drive_req(4'b1000, 3'd6, 16'h0001, {16{8'h66}});
        @(negedge clk);  // RD, two queued
        bus.req_valid = 1'b0;
        total++; if (bus.req_ready !== 1'b0) begin bad++; $display("FAIL rm_full: got %b want 0", bus.req_ready); end
        @(negedge clk);  // MRG
        total++; if (bus.rd_way !== 4'b0010) begin bad++; $display("FAIL rm_mrg_rd_way: got %h want 2", bus.rd_way); end
        total++; if (bus.way_we !== 4'b0000) begin bad++; $display("FAIL rm_mrg_we: got %h want 0", bus.way_we); end
        rst = 1'b1;
        @(negedge clk);  // first cycle after the reset edge
        total++; if (bus.way_we !== 4'b0000) begin bad++; $display("FAIL rm_we_after: got %h want 0", bus.way_we); end
        total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL rm_ready: got %b want 1", bus.req_ready); end
        total++; if (bus.arr_index !== 3'd0) begin bad++; $display("FAIL rm_index: got %h want 0", bus.arr_index); end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            total++; if (bus.way_we !== 4'b0000) begin bad++; $display("FAIL rm_idle_we_%0d: got %h want 0", i, bus.way_we); end
            total++; if (bus.rd_en !== 1'b0) begin bad++; $display("FAIL rm_idle_rd_en_%0d: got %b want 0", i, bus.rd_en); end
            total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL rm_idle_done_%0d: got %b want 0", i, bus.done); end
            total++; if (bus.req_ready !== 1'b1) begin bad++; $display("FAIL rm_idle_ready_%0d: got %b want 1", i, bus.req_ready); end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_way   = 4'b0000;
        bus.req_index = 3'd0;
        bus.req_data  = 128'd0;
        bus.req_mask  = 16'h0000;
        bus.arr_rdata = {16{8'hAA}};
        test_reset();
        test_partial_write();
        test_full_line();
        test_back_to_back();
        test_bad_way();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
